// File: rtl/uart_pkg.sv
// Shared UART definitions (receiver FSM states, divisor default, byte width).
// Pure declarations: no logic, no latency, no backpressure.
package uart_pkg;
  localparam int UART_BAUD_DIV_DEF = 109;
  localparam int UART_DATA_BITS    = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous input, resets to 1 (idle-high lines).
// Latency 2 clk; no backpressure.
module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver; rdy rises 2+HALF_DIV+9*BAUD_DIV clk after RX falls, sticky until clr_rdy.
// No backpressure: an unread byte is overwritten by the next frame. Optional frm_err via UART_RX_FRAME_ERR_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = UART_BAUD_DIV_DEF,
  parameter int HALF_DIV = BAUD_DIV / 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      RX,
  input  logic                      clr_rdy,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rdy
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic                      frm_err
`endif
);
  localparam int            CW       = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_LD   = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LD  = CW'(HALF_DIV - 1);
  localparam logic [3:0]    LAST_BIT = 4'(UART_DATA_BITS - 1);

  rx_state_t                 state;
  logic [CW-1:0]             baud_cnt;
  logic [3:0]                bit_cnt;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      armed;
  logic                      rx_s;
  logic                      sample;

  uart_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (RX),
    .q     (rx_s)
  );

  assign sample = (baud_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      rx_data  <= '0;
      rdy      <= 1'b0;
      armed    <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      frm_err  <= 1'b0;
`endif
    end else begin
      // Later assignments in the FSM override this, so a same-cycle set wins.
      if (clr_rdy) begin
        rdy     <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
        frm_err <= 1'b0;
`endif
      end
      case (state)
        IDLE: begin
          // armed blocks a held-low (break) line from retriggering after STOP.
          if (rx_s) begin
            armed <= 1'b1;
          end else if (armed) begin
            state    <= START;
            baud_cnt <= HALF_LD;
            rdy      <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            frm_err  <= 1'b0;
`endif
          end
        end
        START: begin
          if (!sample) begin
            baud_cnt <= baud_cnt - 1'b1;
          end else if (!rx_s) begin
            state    <= DATA;
            baud_cnt <= BIT_LD;
            bit_cnt  <= '0;
          end else begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (!sample) begin
            baud_cnt <= baud_cnt - 1'b1;
          end else begin
            shreg    <= {rx_s, shreg[UART_DATA_BITS-1:1]};
            bit_cnt  <= bit_cnt + 1'b1;
            baud_cnt <= BIT_LD;
            if (bit_cnt == LAST_BIT) state <= STOP;
          end
        end
        STOP: begin
          if (!sample) begin
            baud_cnt <= baud_cnt - 1'b1;
          end else begin
            state <= IDLE;
            armed <= rx_s;
`ifdef UART_RX_FRAME_ERR_EN
            if (rx_s) begin
              rx_data <= shreg;
              rdy     <= 1'b1;
            end else begin
              frm_err <= 1'b1;
            end
`else
            rx_data <= shreg;
            rdy     <= 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: timed 8N1 frames, event-based reference model, per-cycle compare.
module tb_uart_rx;
  localparam int BAUD = 109;
  localparam int HALF = BAUD / 2;
  localparam int LAT  = 2 + HALF + 9 * BAUD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       clr_rdy = 1'b0;
  logic [7:0] rx_data;
  logic       rdy;
`ifdef UART_RX_FRAME_ERR_EN
  logic       frm_err;
`endif

  uart_rx #(.BAUD_DIV(BAUD), .HALF_DIV(HALF)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (rx),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rdy)
`ifdef UART_RX_FRAME_ERR_EN
    ,
    .frm_err (frm_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  // Model events keyed by the clk edge at which the DUT must show their effect.
  bit         ev_rst[int];
  bit         ev_start[int];
  bit         ev_clr[int];
  bit         ev_set[int];
  bit         ev_ferr[int];
  bit         skip[int];
  logic [7:0] ev_data[int];

  logic       exp_rdy = 1'b0;
  logic       exp_ferr = 1'b0;
  logic [7:0] exp_data = 8'h00;
  logic       prev_rdy = 1'b0;
  int         last_rise = -100000;
  bit         en_cmp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (en_cmp) begin
      int c;
      c = cyc;
      if (ev_rst.exists(c)) begin
        exp_rdy  = 1'b0;
        exp_ferr = 1'b0;
        exp_data = 8'h00;
      end else begin
        if (ev_start.exists(c) || ev_clr.exists(c)) begin
          exp_rdy  = 1'b0;
          exp_ferr = 1'b0;
        end
        if (ev_set.exists(c)) begin
          exp_rdy  = 1'b1;
          exp_data = ev_data[c];
        end
        if (ev_ferr.exists(c)) exp_ferr = 1'b1;
      end
      if (rdy === 1'b1 && prev_rdy !== 1'b1) last_rise = c;
      prev_rdy = rdy;
      if (!skip.exists(c)) begin
        chk("cyc_rdy", rdy, exp_rdy);
        chk("cyc_data", rx_data, exp_data);
`ifdef UART_RX_FRAME_ERR_EN
        chk("cyc_ferr", frm_err, exp_ferr);
`endif
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop, input int gap);
    int t0, t_set;
    bit set;
    t0    = cyc + 1;
    t_set = t0 + LAT;
    set   = 1'b1;
`ifdef UART_RX_FRAME_ERR_EN
    set = stop;
`endif
    ev_start[t0 + 2] = 1'b1;
    if (set) begin
      ev_set[t_set]  = 1'b1;
      ev_data[t_set] = b;
    end else begin
      ev_ferr[t_set] = 1'b1;
    end
    for (int k = -1; k <= 1; k++) skip[t_set + k] = 1'b1;
    rx = 1'b0;
    tick(BAUD);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(BAUD);
    end
    rx = stop;
    tick(BAUD);
    rx = 1'b1;
    tick(gap);
    if (set) chk_rng("latency", last_rise - t0, LAT - 1, LAT + 1);
  endtask

  task automatic pulse_clr(input int edge_c);
    ev_clr[edge_c] = 1'b1;
    while (cyc < edge_c - 1) tick(1);
    clr_rdy = 1'b1;
    tick(1);
    clr_rdy = 1'b0;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int         t0, t2, tset, gap;
    logic [7:0] b;
    bit         stop;

    tick(4);
    chk("reset_rdy", rdy, 1'b0);
    chk("reset_data", rx_data, 8'h00);
`ifdef UART_RX_FRAME_ERR_EN
    chk("reset_ferr", frm_err, 1'b0);
`endif
    rst_n = 1'b1;
    tick(1);
    en_cmp = 1'b1;
    tick(20);

    t0 = cyc + 1;
    send_frame(8'hA5, 1'b1, 30);
    chk("lat_default", last_rise - t0, 1037);
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_rdy", rdy, 1'b1);
    tset = cyc + 500;
    fork
      send_frame(8'h00, 1'b1, 30);
      pulse_clr(tset);
    join
    chk("00_data", rx_data, 8'h00);
    send_frame(8'hFF, 1'b1, 30);
    chk("ff_data", rx_data, 8'hFF);

    // 20-cycle glitch: start detect clears rdy, no frame follows
    t0 = cyc + 1;
    ev_start[t0 + 2] = 1'b1;
    rx = 1'b0;
    tick(20);
    rx = 1'b1;
    tick(HALF + 20);
    chk("glitch_rdy", rdy, 1'b0);
    chk("glitch_data", rx_data, 8'hFF);

    t2   = cyc + 1 + 10 * BAUD;
    tset = cyc + 1 + LAT + 10;
    fork
      begin
        send_frame(8'h3C, 1'b1, 0);
        send_frame(8'hC3, 1'b1, 20);
      end
      pulse_clr(tset);
    join
    chk("b2b_data", rx_data, 8'hC3);
    chk_rng("b2b_latency", last_rise - t2, 1036, 1038);

    tset = cyc + 1 + LAT;
    fork
      send_frame(8'h96, 1'b1, 30);
      pulse_clr(tset);
    join
    chk("clr_same_rdy", rdy, 1'b1);
    tset = cyc + 1 + LAT;
    fork
      send_frame(8'h69, 1'b1, 30);
      pulse_clr(tset + 1);
    join
    chk("clr_next_rdy", rdy, 1'b0);

    send_frame(8'h5A, 1'b0, 30);
`ifdef UART_RX_FRAME_ERR_EN
    chk("stop0_ferr", frm_err, 1'b1);
    chk("stop0_rdy", rdy, 1'b0);
    chk("stop0_data", rx_data, 8'h69);
`else
    chk("stop0_rdy", rdy, 1'b1);
    chk("stop0_data", rx_data, 8'h5A);
`endif

    // reset pulse in the middle of data bit 4, then a clean frame
    b  = 8'h5A;
    t0 = cyc + 1;
    ev_start[t0 + 2] = 1'b1;
    rx = 1'b0;
    tick(BAUD);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      tick(BAUD);
    end
    rx = b[4];
    tick(BAUD / 2);
    ev_rst[cyc + 1] = 1'b1;
    rst_n = 1'b0;
    rx    = 1'b1;
    tick(1);
    rst_n = 1'b1;
    tick(LAT + 20);
    chk("midrst_rdy", rdy, 1'b0);
    chk("midrst_data", rx_data, 8'h00);
    send_frame(8'h81, 1'b1, 30);
    chk("after_rst_data", rx_data, 8'h81);

    for (int n = 0; n < 10; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      gap  = stop ? int'($urandom_range(0, 40)) : int'($urandom_range(5, 40));
      if ($urandom_range(0, 1) == 1) begin
        tset = cyc + 1 + LAT + 2 + int'($urandom_range(0, 40));
        fork
          send_frame(b, stop, gap);
          pulse_clr(tset);
        join
      end else begin
        send_frame(b, stop, gap);
      end
    end

    tick(10);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
